// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor.
// Holds the sequencer state encoding.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell.
// Purely combinational.
module fulladder (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic Sum,
   output logic Cout
);

   assign Sum  = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, one bit per clock, LSB first.
// Subtraction adds the inverted B with an initial carry of one.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             Sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-2:0] res;
   logic             cy;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] nxt;

   fulladder u_fa (
      .A    (opa[0]),
      .B    (opb[0]),
      .Cin  (cy),
      .Sum  (fa_s),
      .Cout (fa_co)
   );

   // new sum bit enters at the MSB end; on the last bit this is the full result
   assign nxt  = {fa_s, res};
   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         opa   <= '0;
         opb   <= '0;
         res   <= '0;
         cy    <= 1'b0;
         cnt   <= '0;
         Sum   <= '0;
         Cout  <= 1'b0;
         Ovf   <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  opa   <= A;
                  opb   <= B ^ {WIDTH{Sub}};
                  cy    <= Sub;
                  cnt   <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               opa <= opa >> 1;
               opb <= opb >> 1;
               res <= nxt[WIDTH-1:1];
               cy  <= fa_co;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  Sum   <= nxt;
                  Cout  <= fa_co;
                  Ovf   <= cy ^ fa_co;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=8.
// Expected values are hand-computed constants.
module tb_serial_addsub;

   localparam int W = 8;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         Sub   = 1'b0;
   logic [W-1:0] A     = '0;
   logic [W-1:0] B     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] Sum;
   logic         Cout;
   logic         Ovf;

   int nvec = 0;
   int nerr = 0;

   serial_addsub #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .Sub   (Sub),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .Sum   (Sum),
      .Cout  (Cout),
      .Ovf   (Ovf)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic s,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input logic ec,
                         input logic eo);
      Sub   = s;
      A     = a;
      B     = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      A     = '1;
      B     = '1;
      Sub   = ~s;
      for (int i = 1; i <= W; i++) begin
         chk({tag, " busy"}, 64'(busy), 64'd1);
         chk({tag, " nodone"}, 64'(done), 64'd0);
         tick();
      end
      chk({tag, " done"}, 64'(done), 64'd1);
      chk({tag, " busyoff"}, 64'(busy), 64'd0);
      chk({tag, " sum"}, 64'(Sum), 64'(es));
      chk({tag, " cout"}, 64'(Cout), 64'(ec));
      chk({tag, " ovf"}, 64'(Ovf), 64'(eo));
      tick();
      chk({tag, " pulse"}, 64'(done), 64'd0);
      chk({tag, " hold"}, 64'(Sum), 64'(es));
   endtask

   initial begin
      #1;
      tick();
      tick();
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst sum", 64'(Sum), 64'd0);
      chk("rst cout", 64'(Cout), 64'd0);
      chk("rst ovf", 64'(Ovf), 64'd0);

      // reset wins over start
      start = 1'b1;
      A     = 8'h11;
      B     = 8'h22;
      tick();
      chk("rst prio", 64'(busy), 64'd0);
      start = 1'b0;
      reset = 1'b0;
      tick();
      chk("idle", 64'(busy), 64'd0);

      run_op("add5a3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
      run_op("addff01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      run_op("sub1020", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
      run_op("sub8001", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

      // start during RUN is ignored
      run_op("clr", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      Sub   = 1'b0;
      A     = 8'h5A;
      B     = 8'h3C;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      A     = 8'h01;
      B     = 8'h01;
      Sub   = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 4; i <= W; i++) begin
         chk("ign busy", 64'(busy), 64'd1);
         chk("ign nodone", 64'(done), 64'd0);
         tick();
      end
      chk("ign done", 64'(done), 64'd1);
      chk("ign sum", 64'(Sum), 64'h96);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("ign single", 64'(done), 64'd0);
         chk("ign idle", 64'(busy), 64'd0);
      end

      // reset mid-RUN abandons the operation
      A     = 8'h5A;
      B     = 8'h3C;
      Sub   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("mid busy", 64'(busy), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid rbusy", 64'(busy), 64'd0);
      chk("mid rdone", 64'(done), 64'd0);
      chk("mid rsum", 64'(Sum), 64'd0);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("mid nodone", 64'(done), 64'd0);
      end
      run_op("add1234", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

      // back-to-back start from DONE
      A     = 8'h5A;
      B     = 8'h3C;
      Sub   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= W; i++) tick();
      chk("b2b done1", 64'(done), 64'd1);
      chk("b2b sum1", 64'(Sum), 64'h96);
      A     = 8'h02;
      B     = 8'h03;
      start = 1'b1;
      tick();
      start = 1'b0;
      A     = 8'hEE;
      for (int i = 1; i <= W; i++) begin
         chk("b2b busy", 64'(busy), 64'd1);
         chk("b2b hold", 64'(Sum), 64'h96);
         chk("b2b nodone", 64'(done), 64'd0);
         tick();
      end
      chk("b2b done2", 64'(done), 64'd1);
      chk("b2b sum2", 64'(Sum), 64'h05);
      chk("b2b cout2", 64'(Cout), 64'd0);
      chk("b2b ovf2", 64'(Ovf), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
